// File: rtl/kernel_int_ctrl_if.sv
// Signal bundle between the processor-side driver and kernel_int_ctrl.
// Adds debug views of per-channel armed/evt_cnt state for checkers.
interface kernel_int_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int COAL_W = 4
);
  // Strobe semantics: kernel_int/kernel_ack/dma_ack are asynchronous levels.
  // Each rising edge, once synchronised, is one event. There is no back-pressure.
  // int_mask/coal_thresh are synchronous and sampled live every cycle.
  logic [NUM_CH-1:0]        kernel_int;
  logic [NUM_CH-1:0]        kernel_ack;
  logic [NUM_CH-1:0]        dma_ack;
  logic [NUM_CH-1:0]        int_mask;
  logic [COAL_W-1:0]        coal_thresh;
  logic                     kernel_irq;
  logic [NUM_CH-1:0]        irq_status;
  logic [NUM_CH-1:0]        irq_overflow;
  logic [NUM_CH-1:0]        armed_dbg;
  logic [NUM_CH*COAL_W-1:0] evt_cnt_dbg;

  modport master (
    output kernel_int, kernel_ack, dma_ack, int_mask, coal_thresh,
    input  kernel_irq, irq_status, irq_overflow, armed_dbg, evt_cnt_dbg
  );

  modport slave (
    input  kernel_int, kernel_ack, dma_ack, int_mask, coal_thresh,
    output kernel_irq, irq_status, irq_overflow, armed_dbg, evt_cnt_dbg
  );
endinterface

// File: rtl/kernel_int_ctrl.sv
// Multi-channel kernel interrupt controller: synchronised edge detection,
// coalescing counters, DMA-gated clear and a masked IRQ OR.
module kernel_int_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 3,
  parameter int COAL_W      = 4
) (
  input logic            dma_axi_aclk,
  input logic            dma_axi_aresetn,
  kernel_int_ctrl_if.slave bus
);

  localparam int SW = 3 * NUM_CH;

  // One shared chain carries {dma, ack, int} for every channel.
  logic [SW-1:0]     sync_s [SYNC_STAGES+1];
  logic [SW-1:0]     edges;
  logic [NUM_CH-1:0] int_edge;
  logic [NUM_CH-1:0] ack_edge;
  logic [NUM_CH-1:0] dma_edge;
  logic [NUM_CH-1:0] clr;

  logic [COAL_W-1:0] cnt_q    [NUM_CH];
  logic [COAL_W-1:0] cnt_d    [NUM_CH];
  logic [NUM_CH-1:0] status_q, status_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] armed_q, armed_d;
  logic [COAL_W-1:0] thr;

  always_ff @(posedge dma_axi_aclk or negedge dma_axi_aresetn) begin
    if (!dma_axi_aresetn) begin
      for (int k = 0; k <= SYNC_STAGES; k++) sync_s[k] <= '0;
    end else begin
      sync_s[0] <= {bus.dma_ack, bus.kernel_ack, bus.kernel_int};
      for (int k = 1; k <= SYNC_STAGES; k++) sync_s[k] <= sync_s[k-1];
    end
  end

  assign edges    = sync_s[SYNC_STAGES-1] & ~sync_s[SYNC_STAGES];
  assign int_edge = edges[NUM_CH-1:0];
  assign ack_edge = edges[2*NUM_CH-1:NUM_CH];
  assign dma_edge = edges[3*NUM_CH-1:2*NUM_CH];
  // Clear uses the armed value from before this cycle's update.
  assign clr      = ack_edge & armed_q;

  always_comb begin
    thr = (bus.coal_thresh == '0) ? COAL_W'(1) : bus.coal_thresh;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c]    = cnt_q[c];
      status_d[c] = status_q[c];
      ovf_d[c]    = ovf_q[c];
      armed_d[c]  = dma_edge[c] ? 1'b1 : (ack_edge[c] ? 1'b0 : armed_q[c]);
      if (clr[c] && int_edge[c]) begin
        // The coincident event survives the clear.
        cnt_d[c]    = COAL_W'(1);
        ovf_d[c]    = 1'b0;
        status_d[c] = (thr == COAL_W'(1));
      end else if (clr[c]) begin
        cnt_d[c]    = '0;
        ovf_d[c]    = 1'b0;
        status_d[c] = 1'b0;
      end else if (int_edge[c]) begin
        if (cnt_q[c] != '1) begin
          cnt_d[c] = cnt_q[c] + COAL_W'(1);
          if ((cnt_q[c] + COAL_W'(1)) >= thr) status_d[c] = 1'b1;
        end else begin
          ovf_d[c]    = 1'b1;
          status_d[c] = 1'b1;
        end
      end else if (cnt_q[c] >= thr) begin
        status_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge dma_axi_aclk or negedge dma_axi_aresetn) begin
    if (!dma_axi_aresetn) begin
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
      status_q <= '0;
      ovf_q    <= '0;
      armed_q  <= '1;
    end else begin
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= cnt_d[c];
      status_q <= status_d;
      ovf_q    <= ovf_d;
      armed_q  <= armed_d;
    end
  end

  assign bus.kernel_irq   = |(status_q & ~bus.int_mask);
  assign bus.irq_status   = status_q;
  assign bus.irq_overflow = ovf_q;
  assign bus.armed_dbg    = armed_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_dbg
    assign bus.evt_cnt_dbg[g*COAL_W +: COAL_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_kernel_int_ctrl.sv
// Directed bench for kernel_int_ctrl with hand-computed expectations.
module tb_kernel_int_ctrl;

  localparam int NUM_CH = 4;
  localparam int COAL_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  kernel_int_ctrl_if #(.NUM_CH(NUM_CH), .COAL_W(COAL_W)) bus ();

  kernel_int_ctrl #(.NUM_CH(NUM_CH), .SYNC_STAGES(3), .COAL_W(COAL_W)) dut (
    .dma_axi_aclk    (clk),
    .dma_axi_aresetn (rst_n),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind: 0 = kernel_int, 1 = kernel_ack, 2 = dma_ack; fully settles afterwards
  task automatic pulse(input int kind, input int ch);
    case (kind)
      0: bus.kernel_int[ch] = 1'b1;
      1: bus.kernel_ack[ch] = 1'b1;
      default: bus.dma_ack[ch] = 1'b1;
    endcase
    wait_edges(2);
    case (kind)
      0: bus.kernel_int[ch] = 1'b0;
      1: bus.kernel_ack[ch] = 1'b0;
      default: bus.dma_ack[ch] = 1'b0;
    endcase
    wait_edges(5);
  endtask

  function automatic logic [COAL_W-1:0] cnt_of(input int ch);
    return bus.evt_cnt_dbg[ch*COAL_W +: COAL_W];
  endfunction

  initial begin
    bus.kernel_int  = '0;
    bus.kernel_ack  = '0;
    bus.dma_ack     = '0;
    bus.int_mask    = '0;
    bus.coal_thresh = '0;
    #12;
    check("rst_status", bus.irq_status, 4'h0);
    check("rst_ovf", bus.irq_overflow, 4'h0);
    check("rst_irq", bus.kernel_irq, 1'b0);
    check("rst_armed", bus.armed_dbg, 4'hf);
    rst_n = 1'b1;
    wait_edges(2);

    // Latency: ch0, thr=1
    bus.coal_thresh = 4'd1;
    bus.kernel_int[0] = 1'b1;
    wait_edges(1);
    wait_edges(2);
    check("lat_before", bus.irq_status, 4'h0);
    wait_edges(1);
    check("lat_status", bus.irq_status, 4'h1);
    check("lat_irq", bus.kernel_irq, 1'b1);
    bus.kernel_int[0] = 1'b0;
    bus.kernel_ack[0] = 1'b1;
    wait_edges(1);
    bus.kernel_ack[0] = 1'b0;
    wait_edges(2);
    check("clr_before", bus.irq_status, 4'h1);
    wait_edges(1);
    check("clr_status", bus.irq_status, 4'h0);
    check("clr_irq", bus.kernel_irq, 1'b0);
    check("clr_disarm", bus.armed_dbg[0], 1'b0);
    wait_edges(4);

    // Coalescing: ch2, thr=3
    bus.coal_thresh = 4'd3;
    pulse(0, 2);
    check("coal_p1", bus.irq_status[2], 1'b0);
    pulse(0, 2);
    check("coal_p2", bus.irq_status[2], 1'b0);
    pulse(0, 2);
    check("coal_p3", bus.irq_status[2], 1'b1);
    check("coal_cnt", cnt_of(2), 4'd3);

    // Masking with ch2 pending
    bus.int_mask = 4'b0100;
    #1;
    check("mask_irq", bus.kernel_irq, 1'b0);
    check("mask_status", bus.irq_status[2], 1'b1);
    bus.int_mask = 4'b0000;
    #1;
    check("unmask_irq", bus.kernel_irq, 1'b1);
    pulse(1, 2);
    check("ch2_clear", bus.irq_status[2], 1'b0);

    // DMA re-arm gating on ch1
    bus.coal_thresh = 4'd1;
    pulse(0, 1);
    check("arm_ev1", bus.irq_status[1], 1'b1);
    pulse(1, 1);
    check("arm_clr1", bus.irq_status[1], 1'b0);
    pulse(0, 1);
    check("arm_ev2", bus.irq_status[1], 1'b1);
    pulse(1, 1);
    check("arm_ignored", bus.irq_status[1], 1'b1);
    pulse(2, 1);
    check("arm_rearmed", bus.armed_dbg[1], 1'b1);
    pulse(1, 1);
    check("arm_clr2", bus.irq_status[1], 1'b0);

    // Saturation: ch3, thr=15
    bus.coal_thresh = 4'd15;
    for (int i = 1; i <= 14; i++) pulse(0, 3);
    check("sat_p14", bus.irq_status[3], 1'b0);
    pulse(0, 3);
    check("sat_p15", bus.irq_status[3], 1'b1);
    check("sat_p15_ovf", bus.irq_overflow[3], 1'b0);
    pulse(0, 3);
    check("sat_p16_ovf", bus.irq_overflow[3], 1'b1);
    pulse(0, 3);
    check("sat_p17_ovf", bus.irq_overflow[3], 1'b1);
    check("sat_cnt", cnt_of(3), 4'd15);
    pulse(1, 3);
    check("sat_clr_status", bus.irq_status[3], 1'b0);
    check("sat_clr_ovf", bus.irq_overflow[3], 1'b0);
    check("sat_clr_cnt", cnt_of(3), 4'd0);

    // Coincident int and valid ack on ch0
    bus.coal_thresh = 4'd1;
    pulse(2, 0);
    pulse(0, 0);
    pulse(0, 0);
    check("coin_pre_cnt", cnt_of(0), 4'd2);
    bus.kernel_int[0] = 1'b1;
    bus.kernel_ack[0] = 1'b1;
    wait_edges(2);
    bus.kernel_int[0] = 1'b0;
    bus.kernel_ack[0] = 1'b0;
    wait_edges(5);
    check("coin_cnt", cnt_of(0), 4'd1);
    check("coin_status", bus.irq_status[0], 1'b1);

    // Asynchronous reset mid-count
    bus.coal_thresh = 4'd15;
    pulse(0, 3);
    pulse(0, 3);
    check("mid_cnt", cnt_of(3), 4'd2);
    check("mid_irq", bus.kernel_irq, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_status", bus.irq_status, 4'h0);
    check("arst_ovf", bus.irq_overflow, 4'h0);
    check("arst_irq", bus.kernel_irq, 1'b0);
    check("arst_cnt", bus.evt_cnt_dbg, 16'h0);
    check("arst_armed", bus.armed_dbg, 4'hf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
